// File: rtl/mem_pkg.sv
// Shared types and defaults for the single-port RAM block.
package mem_pkg;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_WIDTH = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEF_ADDR_W = addr_w(DEF_DEPTH);

  typedef logic [DEF_WIDTH-1:0]  word_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
endpackage

// File: rtl/mem_if.sv
// Memory bus: the test side is master, the RAM is slave.
interface mem_if
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int ADDR_W = addr_w(DEPTH);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;

  modport master (output read, write, addr, data_in, input data_out);
  modport slave  (input read, write, addr, data_in, output data_out);
endinterface

// File: rtl/mem_array.sv
// Storage array: clocked write port, combinational read, async clear.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] words [DEPTH];
  logic             in_range;

  // Only a non-power-of-2 depth leaves unused address codes to guard.
  generate
    if ((1 << ADDR_W) == DEPTH) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      assign in_range = addr < ADDR_W'(DEPTH);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) words[i] <= '0;
    end else if (we && in_range) begin
      words[addr] <= wdata;
    end
  end

  assign rdata = in_range ? words[addr] : '0;
endmodule

// File: rtl/mem.sv
// Single-port synchronous RAM with registered read data.
module mem
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic  clk,
  input  logic  rst_n,
  mem_if.slave  bus
);
  logic [WIDTH-1:0] rdata;

  mem_array #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.write),
    .addr  (bus.addr),
    .wdata (bus.data_in),
    .rdata (rdata)
  );

  // rdata reflects the pre-write contents, so read+write returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bus.data_out <= '0;
    else if (bus.read) bus.data_out <= rdata;
  end
endmodule

// File: tb/tb_mem.sv
// Randomised self-checking bench for mem against an array reference model.
module tb_mem;
  import mem_pkg::*;
  localparam int DEPTH = 32;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  mem_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();
  mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  word_t model [DEPTH];
  word_t exp_out;
  int    total  = 0;
  int    passed = 0;

  // Drive one operation after a negedge; return at the next negedge with the model updated.
  task automatic step(input logic r, input logic w, input addr_t a, input word_t d);
    bus.read = r; bus.write = w; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    if (r) exp_out = model[a];
    if (w) model[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_out = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.read = 0; bus.write = 0; bus.addr = '0; bus.data_in = '0;
    clear_model();
    repeat (2) @(negedge clk);
    total++;
    if (bus.data_out !== 8'h00) $display("FAIL reset_hold data_out=%h want 00", bus.data_out);
    else passed++;
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      step(1, 0, addr_t'(a), word_t'($urandom));
      total++;
      if (bus.data_out !== 8'h00) $display("FAIL reset_read[%0d] data_out=%h want 00", a, bus.data_out);
      else passed++;
    end
  endtask

  task automatic test_ascii();
    for (int a = 0; a < DEPTH; a++) step(0, 1, addr_t'(a), word_t'(8'h40 + a));
    for (int a = 0; a < DEPTH; a++) begin
      step(1, 0, addr_t'(a), '0);
      total++;
      if (bus.data_out !== exp_out) $display("FAIL ascii[%0d] data_out=%h want %h", a, bus.data_out, exp_out);
      else passed++;
    end
  endtask

  task automatic test_overwrite();
    step(0, 1, 5, 8'h41);
    step(0, 1, 5, 8'h5A);
    step(1, 0, 5, '0);
    total++;
    if (bus.data_out !== 8'h5A) $display("FAIL overwrite5 data_out=%h want 5a", bus.data_out);
    else passed++;
    for (int a = 4; a <= 6; a += 2) begin
      step(1, 0, addr_t'(a), '0);
      total++;
      if (bus.data_out !== exp_out) $display("FAIL overwrite_nbr[%0d] data_out=%h want %h", a, bus.data_out, exp_out);
      else passed++;
    end
  endtask

  task automatic test_simul();
    step(0, 1, 3, 8'h33);
    step(1, 1, 3, 8'h77);
    total++;
    if (bus.data_out !== 8'h33) $display("FAIL simul_old data_out=%h want 33", bus.data_out);
    else passed++;
    step(1, 0, 3, '0);
    total++;
    if (bus.data_out !== 8'h77) $display("FAIL simul_new data_out=%h want 77", bus.data_out);
    else passed++;
  endtask

  task automatic test_hold();
    step(0, 1, 7, 8'h62);
    step(1, 0, 7, '0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, addr_t'($urandom_range(0, DEPTH-1)), word_t'($urandom));
      total++;
      if (bus.data_out !== 8'h62) $display("FAIL hold[%0d] data_out=%h want 62", i, bus.data_out);
      else passed++;
    end
    for (int a = 0; a < DEPTH; a++) begin
      step(1, 0, addr_t'(a), '0);
      total++;
      if (bus.data_out !== exp_out) $display("FAIL hold_mem[%0d] data_out=%h want %h", a, bus.data_out, exp_out);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      addr_t a = addr_t'($urandom_range(0, DEPTH-1));
      step(0, 1, a, word_t'($urandom));
      step(1, 0, a, '0);
      total++;
      if (bus.data_out !== exp_out) $display("FAIL b2b[%0d] addr=%0d data_out=%h want %h", i, a, bus.data_out, exp_out);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), addr_t'($urandom_range(0, DEPTH-1)), word_t'($urandom));
      total++;
      if (bus.data_out !== exp_out) $display("FAIL rand[%0d] data_out=%h want %h", i, bus.data_out, exp_out);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, 10, 8'h55);
    step(1, 0, 10, '0);
    total++;
    if (bus.data_out !== 8'h55) $display("FAIL pre_reset data_out=%h want 55", bus.data_out);
    else passed++;
    bus.read = 1; bus.write = 1; bus.addr = 10; bus.data_in = 8'hAA;
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    total++;
    if (bus.data_out !== 8'h00) $display("FAIL async_reset data_out=%h want 00", bus.data_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 9; a <= 11; a++) begin
      step(1, 0, addr_t'(a), '0);
      total++;
      if (bus.data_out !== 8'h00) $display("FAIL post_reset[%0d] data_out=%h want 00", a, bus.data_out);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_ascii();
    test_overwrite();
    test_simul();
    test_hold();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
